axi4_slave_mul_wrapper: RTL
===========================

Name: axi4_slave_mul_wrapper

Overview:
AXI4-style responder paired with the existing AXI4 master wrapper. It receives two SZ-bit operands as 4-beat write bursts and computes their 2*SZ-bit product with a sequential shift-add multiplier. It returns the product as an 8-beat read burst.
It sits on the slave side of the AXI4 leg of the AXI4/Avalon comparison testbench.

Parameters:
SZ, 32, operand width; fixed at 32 (SZ/DSZ = 4 beats per operand)
ASZ, 2, address width of awaddr/araddr
DSZ, 8, data beat width

Ports:
clk  input  1  clock
_rst  input  1  reset, asynchronous, active-low
awaddr  input  ASZ  write target: 0 = operand A, 1 = operand B
awvalid  input  1  write address valid
awready  output  1  write address ready
wdata  input  DSZ  write beat data
wvalid  input  1  write beat valid
wready  output  1  write beat ready
wlast  input  1  last write beat
bresp  output  1  write response, 1 = ok
bvalid  output  1  write response valid
bready  input  1  write response ready
araddr  input  ASZ  read target: 0 = product
arvalid  input  1  read address valid
arready  output  1  read address ready
rdata  output  DSZ  read beat data
rvalid  output  1  read beat valid
rready  input  1  read beat ready
rlast  output  1  last read beat
rresp  output  1  read response, 1 = ok
product  output  2*SZ  current committed product (debug/observe)
mul_busy  output  1  multiplier iterating

Behaviour:
- All outputs registered. Reset (_rst low, async) drives:
  - awready=0, wready=0, bvalid=0, bresp=0, arready=0, rvalid=0, rlast=0, rdata=0, rresp=0, mul_busy=0.
  - Operands, product, snapshot and pending flag = 0.
  - Both FSMs go to IDLE.
  - First cycle after reset release: awready=1, arready=1.
- Write FSM W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awready=1. On awvalid&awready: latch awaddr, beat=0, go W_DATA with awready=0, wready=1.
  - W_DATA: each wvalid&wready writes wdata into a shadow register at bits [8*beat+7 : 8*beat], then beat++.
  - Beat 3 always ends the burst: wready=0, bvalid=1, go W_RESP.
  - bresp=1 only if latched awaddr<=1, wlast=1 on beat 3, and wlast=0 on beats 0..2. Otherwise bresp=0.
  - W_RESP: on bvalid&bready, bvalid=0 and return to W_IDLE (awready=1 next cycle).
  - The shadow is committed to A or B in the same cycle as the B handshake, and only when bresp=1. bresp=0 leaves the operands unchanged.
  - A successful commit requests a multiply.
- Multiplier:
  - Unsigned shift-add, one iteration per cycle, SZ iterations.
  - Start: mul_busy=1; accumulator=0; working copies of A and B taken at start.
  - After iteration SZ-1: product <= accumulator (atomic 64-bit update), mul_busy=0.
  - Latency: product valid SZ+1 cycles after the commit edge.
  - Request while busy: set pending. The current run completes, then a restart begins on the next cycle using the latest A and B.
  - Request arriving on the same cycle as the final iteration: treated as pending.
  - Multiple requests while busy collapse into one pending flag.
- Read FSM R_IDLE -> R_DATA:
  - R_IDLE: arready=1. On arvalid&arready: snapshot = product (the value before any same-cycle update), rpos=0, rresp=(araddr==0), arready=0, rvalid=1. The burst therefore always returns a coherent product.
  - R_DATA: rdata = snapshot byte rpos if rresp=1, else 0. rlast=1 exactly when rpos=7.
  - On rvalid&rready: rpos++ and the next byte is presented the following cycle.
  - rready low: rdata, rlast and rvalid are held.
  - Handshake with rlast=1: rvalid=0, rlast=0, return to R_IDLE (arready=1 next cycle).
  - rresp=0 bursts still run the full 8 beats.
- Independence and reset:
  - Read and write channels run concurrently. A read may overlap a write or a multiply.
  - Reset asserted mid-burst or mid-multiply aborts immediately to the reset state. No partial commit.

Test Plan:
1. Write A=3 (awaddr 0), then B=5 (awaddr 1); wait 34 cycles; read araddr 0 -> bresp=1 twice; rdata beats 0F,00,00,00,00,00,00,00; rlast only on beat 8; rresp=1.
2. A=0xFFFFFFFF, B=0xFFFFFFFF -> product=0xFFFFFFFE00000001; read beats 01,00,00,00,FE,FF,FF,FF.
3. Write with awaddr=2, or wlast on beat 1 -> bresp=0; A/B/product unchanged; no multiply started (mul_busy stays 0).
4. Write B=7 while mul_busy=1 from the previous commit -> pending restart; final product = A*7 exactly SZ+1 cycles after the first run ends.
5. Read with araddr=1 and rready toggled 1,0,0,1,... -> 8 beats, rdata=0, rresp=0, outputs held during rready=0; arready=1 the cycle after the last beat.
6. Pull _rst low during beat 2 of a write and during a read burst -> all outputs return to reset values asynchronously; after release, awready=arready=1 and product=0.

Source files
------------

// File: rtl/axi4_slave_mul_wrapper.sv
// AXI4-style responder: two SZ-bit operands arrive as write bursts, a sequential
// shift-add multiplier forms the 2*SZ-bit product, which is returned as a read burst.
module axi4_slave_mul_wrapper #(
  parameter int SZ  = 32,
  parameter int ASZ = 2,
  parameter int DSZ = 8
) (
  input  logic            clk,
  input  logic            _rst,
  input  logic [ASZ-1:0]  awaddr,
  input  logic            awvalid,
  output logic            awready,
  input  logic [DSZ-1:0]  wdata,
  input  logic            wvalid,
  output logic            wready,
  input  logic            wlast,
  output logic            bresp,
  output logic            bvalid,
  input  logic            bready,
  input  logic [ASZ-1:0]  araddr,
  input  logic            arvalid,
  output logic            arready,
  output logic [DSZ-1:0]  rdata,
  output logic            rvalid,
  input  logic            rready,
  output logic            rlast,
  output logic            rresp,
  output logic [2*SZ-1:0] product,
  output logic            mul_busy
);

  localparam int WBEATS = SZ / DSZ;
  localparam int RBEATS = 2 * SZ / DSZ;
  localparam int BW     = $clog2(WBEATS);
  localparam int RW     = $clog2(RBEATS);
  localparam int CW     = $clog2(SZ);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t       w_state, w_next;
  logic [ASZ-1:0] w_addr, w_addr_d;
  logic [BW-1:0]  beat, beat_d;
  logic [SZ-1:0]  shadow, shadow_d;
  logic           w_ok, w_ok_d;
  logic           awready_d, wready_d, bvalid_d, bresp_d;
  logic           commit;

  r_state_t        r_state, r_next;
  logic [2*SZ-1:0] snapshot, snapshot_d;
  logic [RW-1:0]   rpos, rpos_d;
  logic            arready_d, rvalid_d, rlast_d, rresp_d;
  logic [DSZ-1:0]  rdata_d;

  logic [SZ-1:0]   op_a, op_b, work_b;
  logic [2*SZ-1:0] work_a, acc, acc_sum;
  logic [CW-1:0]   cnt;
  logic            pending;

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      w_state <= W_IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= 1'b0;
      w_addr  <= '0;
      beat    <= '0;
      shadow  <= '0;
      w_ok    <= 1'b0;
    end else begin
      w_state <= w_next;
      awready <= awready_d;
      wready  <= wready_d;
      bvalid  <= bvalid_d;
      bresp   <= bresp_d;
      w_addr  <= w_addr_d;
      beat    <= beat_d;
      shadow  <= shadow_d;
      w_ok    <= w_ok_d;
    end
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (awvalid && awready) w_next = W_DATA;
      W_DATA:  if (wvalid && wready && beat == BW'(WBEATS - 1)) w_next = W_RESP;
      W_RESP:  if (bvalid && bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // w_ok stays set only while wlast is low on every beat before the final one
  always_comb begin
    awready_d = awready;
    wready_d  = wready;
    bvalid_d  = bvalid;
    bresp_d   = bresp;
    w_addr_d  = w_addr;
    beat_d    = beat;
    shadow_d  = shadow;
    w_ok_d    = w_ok;
    case (w_state)
      W_IDLE: begin
        awready_d = 1'b1;
        if (awvalid && awready) begin
          awready_d = 1'b0;
          wready_d  = 1'b1;
          w_addr_d  = awaddr;
          beat_d    = '0;
          w_ok_d    = 1'b1;
        end
      end
      W_DATA: begin
        if (wvalid && wready) begin
          shadow_d[DSZ*beat +: DSZ] = wdata;
          if (beat == BW'(WBEATS - 1)) begin
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            bresp_d  = w_ok && wlast && (w_addr <= ASZ'(1));
          end else begin
            beat_d = beat + 1'b1;
            if (wlast) w_ok_d = 1'b0;
          end
        end
      end
      W_RESP: begin
        if (bvalid && bready) begin
          bvalid_d  = 1'b0;
          bresp_d   = 1'b0;
          awready_d = 1'b1;
        end
      end
      default: begin
        awready_d = 1'b0;
        wready_d  = 1'b0;
        bvalid_d  = 1'b0;
      end
    endcase
  end

  assign commit  = (w_state == W_RESP) && bvalid && bready && bresp;
  assign acc_sum = acc + (work_b[0] ? work_a : '0);

  // Every commit lands in pending; an idle multiplier starts from it one cycle later,
  // so restarts always see the operands committed so far
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      op_a     <= '0;
      op_b     <= '0;
      work_a   <= '0;
      work_b   <= '0;
      acc      <= '0;
      cnt      <= '0;
      product  <= '0;
      mul_busy <= 1'b0;
      pending  <= 1'b0;
    end else begin
      if (commit) begin
        if (w_addr == '0) op_a <= shadow;
        else              op_b <= shadow;
      end
      if (mul_busy) begin
        work_a <= work_a << 1;
        work_b <= work_b >> 1;
        cnt    <= cnt + 1'b1;
        if (cnt == CW'(SZ - 1)) begin
          product  <= acc_sum;
          mul_busy <= 1'b0;
        end else begin
          acc <= acc_sum;
        end
      end else if (pending) begin
        mul_busy <= 1'b1;
        acc      <= '0;
        work_a   <= {{SZ{1'b0}}, op_a};
        work_b   <= op_b;
        cnt      <= '0;
      end
      if (commit)                    pending <= 1'b1;
      else if (!mul_busy && pending) pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      r_state  <= R_IDLE;
      arready  <= 1'b0;
      rvalid   <= 1'b0;
      rlast    <= 1'b0;
      rdata    <= '0;
      rresp    <= 1'b0;
      snapshot <= '0;
      rpos     <= '0;
    end else begin
      r_state  <= r_next;
      arready  <= arready_d;
      rvalid   <= rvalid_d;
      rlast    <= rlast_d;
      rdata    <= rdata_d;
      rresp    <= rresp_d;
      snapshot <= snapshot_d;
      rpos     <= rpos_d;
    end
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (arvalid && arready) r_next = R_DATA;
      R_DATA:  if (rvalid && rready && rlast) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // The snapshot freezes the product at the address handshake so a burst stays coherent
  always_comb begin
    arready_d  = arready;
    rvalid_d   = rvalid;
    rlast_d    = rlast;
    rdata_d    = rdata;
    rresp_d    = rresp;
    snapshot_d = snapshot;
    rpos_d     = rpos;
    case (r_state)
      R_IDLE: begin
        arready_d = 1'b1;
        if (arvalid && arready) begin
          arready_d  = 1'b0;
          rvalid_d   = 1'b1;
          rlast_d    = 1'b0;
          rpos_d     = '0;
          snapshot_d = product;
          rresp_d    = (araddr == '0);
          rdata_d    = (araddr == '0) ? product[DSZ-1:0] : '0;
        end
      end
      R_DATA: begin
        if (rvalid && rready) begin
          if (rlast) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            rdata_d   = '0;
            arready_d = 1'b1;
          end else begin
            rpos_d  = rpos + 1'b1;
            rlast_d = (rpos_d == RW'(RBEATS - 1));
            rdata_d = rresp ? snapshot[DSZ*rpos_d +: DSZ] : '0;
          end
        end
      end
      default: begin
        arready_d = 1'b0;
        rvalid_d  = 1'b0;
        rlast_d   = 1'b0;
      end
    endcase
  end

endmodule
